// File: rtl/wb_mem_ctrl_if.sv
// Data-memory request/ready bus between the writeback sequencer (master) and data memory (slave).
interface wb_mem_ctrl_if #(
  parameter int WIDTH = 32
);
  logic             MemReq;
  logic             MemWE;
  logic [WIDTH-1:0] MemAddr;
  logic [WIDTH-1:0] ReadData;
  logic             MemReady;

  modport master (
    output MemReq,
    output MemWE,
    output MemAddr,
    input  ReadData,
    input  MemReady
  );

  modport slave (
    input  MemReq,
    input  MemWE,
    input  MemAddr,
    output ReadData,
    output MemReady
  );
endinterface

// File: rtl/wb_mem_ctrl.sv
// Writeback/memory sequencer: ALU results pass through, loads/stores stall the core until MemReady or timeout.
// Optional WB_ZERO_WAIT_EN lets an access complete in the issuing IDLE cycle when MemReady is already high.
module wb_mem_ctrl #(
  parameter int WIDTH   = 32,
  parameter int TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             Load,
  input  logic             Store,
  input  logic             RegWriteIn,
  input  logic [WIDTH-1:0] ALUResult,
  output logic             ResultSrc,
  output logic [WIDTH-1:0] Result,
  output logic             RegWrite,
  output logic             Stall,
  output logic             Fault,
  wb_mem_ctrl_if.master    mem
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCESS,
    S_WRITEBACK,
    S_FAULT
  } state_t;

  state_t           state_q, state_d;
  logic             op_load_q, op_load_d;
  logic [WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [WIDTH-1:0] load_data_q, load_data_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic             mem_req, mem_we, stall, reg_write, result_src, fault;
  logic [WIDTH-1:0] addr_out;

  always_comb begin
    state_d     = state_q;
    op_load_d   = op_load_q;
    mem_addr_d  = mem_addr_q;
    load_data_d = load_data_q;
    cnt_d       = cnt_q;
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    addr_out    = mem_addr_q;
    stall       = 1'b0;
    reg_write   = 1'b0;
    result_src  = 1'b0;
    fault       = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (Load && Store) begin
          stall   = 1'b1;
          state_d = S_FAULT;
        end else if (Load || Store) begin
          // Address goes out combinationally so the request starts in the issue cycle.
          mem_req    = 1'b1;
          mem_we     = Store;
          stall      = 1'b1;
          addr_out   = ALUResult;
          mem_addr_d = ALUResult;
          op_load_d  = Load;
          cnt_d      = '0;
`ifdef WB_ZERO_WAIT_EN
          if (mem.MemReady) begin
            if (Load) begin
              load_data_d = mem.ReadData;
              state_d     = S_WRITEBACK;
            end else begin
              state_d = S_IDLE;
            end
          end else begin
            state_d = S_ACCESS;
          end
`else
          state_d = S_ACCESS;
`endif
        end else begin
          reg_write = RegWriteIn;
        end
      end

      S_ACCESS: begin
        mem_req = 1'b1;
        mem_we  = ~op_load_q;
        stall   = 1'b1;
        cnt_d   = cnt_q + CW'(1);
        // A response on the last allowed cycle still completes normally.
        if (mem.MemReady) begin
          if (op_load_q) begin
            load_data_d = mem.ReadData;
            state_d     = S_WRITEBACK;
          end else begin
            state_d = S_IDLE;
          end
        end else if (cnt_q == CNT_LAST) begin
          state_d = S_FAULT;
        end
      end

      S_WRITEBACK: begin
        result_src = 1'b1;
        reg_write  = 1'b1;
        state_d    = S_IDLE;
      end

      S_FAULT: begin
        fault = 1'b1;
        stall = 1'b1;
      end

      default: state_d = S_IDLE;
    endcase

    if (reset) begin
      mem_req    = 1'b0;
      mem_we     = 1'b0;
      stall      = 1'b0;
      reg_write  = 1'b0;
      result_src = 1'b0;
      fault      = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      op_load_q   <= 1'b0;
      mem_addr_q  <= '0;
      load_data_q <= '0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      op_load_q   <= op_load_d;
      mem_addr_q  <= mem_addr_d;
      load_data_q <= load_data_d;
      cnt_q       <= cnt_d;
    end
  end

  assign mem.MemReq  = mem_req;
  assign mem.MemWE   = mem_we;
  assign mem.MemAddr = addr_out;
  assign Stall       = stall;
  assign RegWrite    = reg_write;
  assign ResultSrc   = result_src;
  assign Fault       = fault;
  assign Result      = result_src ? load_data_q : ALUResult;

endmodule

// File: tb/tb_wb_mem_ctrl.sv
// Bench for wb_mem_ctrl: transaction-level model of stall/writeback timing driven with random latencies.
module tb_wb_mem_ctrl;
  localparam int W  = 32;
  localparam int TO = 15;
`ifdef WB_ZERO_WAIT_EN
  localparam bit ZW = 1'b1;
`else
  localparam bit ZW = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset;
  logic         Load, Store, RegWriteIn;
  logic [W-1:0] ALUResult;
  logic         ResultSrc, RegWrite, Stall, Fault;
  logic [W-1:0] Result;

  int n_checks = 0;
  int n_fails  = 0;

  wb_mem_ctrl_if #(.WIDTH(W)) mif ();

  wb_mem_ctrl #(.WIDTH(W), .TIMEOUT(TO)) dut (
    .clk        (clk),
    .reset      (reset),
    .Load       (Load),
    .Store      (Store),
    .RegWriteIn (RegWriteIn),
    .ALUResult  (ALUResult),
    .ResultSrc  (ResultSrc),
    .Result     (Result),
    .RegWrite   (RegWrite),
    .Stall      (Stall),
    .Fault      (Fault),
    .mem        (mif)
  );

  always #5 clk = ~clk;

  task automatic drive(input bit ld, input bit st, input bit rwi, input logic [W-1:0] alu,
                       input bit rdy, input logic [W-1:0] rd);
    @(posedge clk);
    #1;
    Load         = ld;
    Store        = st;
    RegWriteIn   = rwi;
    ALUResult    = alu;
    mif.MemReady = rdy;
    mif.ReadData = rd;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    reset = 1'b1;
    Load = 1'b0; Store = 1'b0; RegWriteIn = 1'b0; mif.MemReady = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
  endtask

  // op: 0 = ALU, 1 = load, 2 = store; memory raises MemReady from issue-relative cycle k onward.
  task automatic run_txn(input string name, input int op, input int k,
                         input logic [W-1:0] addr, input logic [W-1:0] data, input bit rwi);
    int eff_k, last;
    bit tmo;
    eff_k = (k == 0 && !ZW) ? 1 : k;
    tmo   = (op != 0) && (k > TO);
    last  = (op == 0) ? 0 : (tmo ? TO + 1 : eff_k + 1);
    for (int c = 0; c <= last; c++) begin
      bit e_stall, e_req, e_we, e_rw, e_src, e_flt, req_phase;
      logic [W-1:0] e_res, alu_v;
      req_phase = (op != 0) && (c <= (tmo ? TO : eff_k));
      alu_v = (c == 0) ? addr : W'($urandom);
      if (op == 0)
        drive(1'b0, 1'b0, rwi, addr, 1'($urandom_range(0, 1)), W'($urandom));
      else if (req_phase)
        drive(op == 1, op == 2, (op == 1) ? rwi : 1'b0, alu_v, c >= k, (c >= k) ? data : W'($urandom));
      else
        drive((op == 1 && !tmo) ? 1'($urandom_range(0, 1)) : 1'b0, 1'b0, 1'b0, alu_v, 1'b0, W'($urandom));
      @(negedge clk);

      e_flt = tmo && (c == last);
      e_we = 1'b0; e_rw = 1'b0; e_src = 1'b0; e_res = alu_v;
      if (op == 0) begin
        e_stall = 1'b0; e_req = 1'b0; e_rw = rwi;
      end else if (req_phase) begin
        e_stall = 1'b1; e_req = 1'b1; e_we = (op == 2);
      end else if (e_flt) begin
        e_stall = 1'b1; e_req = 1'b0;
      end else if (op == 1) begin
        e_stall = 1'b0; e_req = 1'b0; e_rw = 1'b1; e_src = 1'b1; e_res = data;
      end else begin
        e_stall = 1'b0; e_req = 1'b0;
      end

      n_checks++;
      if (Stall !== e_stall) begin
        n_fails++; $display("FAIL %s c%0d Stall got %b exp %b", name, c, Stall, e_stall);
      end
      n_checks++;
      if (mif.MemReq !== e_req) begin
        n_fails++; $display("FAIL %s c%0d MemReq got %b exp %b", name, c, mif.MemReq, e_req);
      end
      n_checks++;
      if (mif.MemWE !== e_we) begin
        n_fails++; $display("FAIL %s c%0d MemWE got %b exp %b", name, c, mif.MemWE, e_we);
      end
      if (e_req) begin
        n_checks++;
        if (mif.MemAddr !== addr) begin
          n_fails++; $display("FAIL %s c%0d MemAddr got %h exp %h", name, c, mif.MemAddr, addr);
        end
      end
      n_checks++;
      if (RegWrite !== e_rw) begin
        n_fails++; $display("FAIL %s c%0d RegWrite got %b exp %b", name, c, RegWrite, e_rw);
      end
      n_checks++;
      if (ResultSrc !== e_src) begin
        n_fails++; $display("FAIL %s c%0d ResultSrc got %b exp %b", name, c, ResultSrc, e_src);
      end
      n_checks++;
      if (Result !== e_res) begin
        n_fails++; $display("FAIL %s c%0d Result got %h exp %h", name, c, Result, e_res);
      end
      n_checks++;
      if (Fault !== e_flt) begin
        n_fails++; $display("FAIL %s c%0d Fault got %b exp %b", name, c, Fault, e_flt);
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    Load = 1'b1; Store = 1'b0; RegWriteIn = 1'b1; ALUResult = 32'h1234;
    mif.MemReady = 1'b1; mif.ReadData = 32'h5678;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if ({mif.MemReq, mif.MemWE, Stall, RegWrite, ResultSrc, Fault} !== 6'b0) begin
      n_fails++;
      $display("FAIL reset_forced req/we/stall/rw/src/flt got %b exp 000000",
               {mif.MemReq, mif.MemWE, Stall, RegWrite, ResultSrc, Fault});
    end
    drive(1'b0, 1'b0, 1'b0, 32'd55, 1'b0, 32'd0);
    reset = 1'b0;
    @(negedge clk);
    n_checks++;
    if (mif.MemAddr !== 32'd0) begin
      n_fails++; $display("FAIL reset_addr MemAddr got %h exp 0", mif.MemAddr);
    end
    n_checks++;
    if ({Stall, Fault, ResultSrc} !== 3'b000 || Result !== 32'd55) begin
      n_fails++; $display("FAIL reset_idle stall/flt/src got %b result %0d exp 000 result 55",
                          {Stall, Fault, ResultSrc}, Result);
    end
  endtask

  task automatic test_alu();
    run_txn("alu_rw1", 0, 0, 32'd100, 32'd0, 1'b1);
    run_txn("alu_rw0", 0, 0, 32'd7, 32'd0, 1'b0);
  endtask

  task automatic test_load();
    run_txn("load_k3", 1, 3, 32'h40, 32'd200, 1'b1);
  endtask

  task automatic test_store();
    run_txn("store_k1", 2, 1, 32'h44, 32'hdead_beef, 1'b0);
  endtask

  task automatic test_ready_at_limit();
    run_txn("load_k15", 1, TO, 32'h80, 32'hcafe_f00d, 1'b1);
  endtask

  task automatic test_timeout();
    run_txn("timeout", 1, TO + 5, 32'h90, 32'd0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1, W'($urandom),
            1'($urandom_range(0, 1)), W'($urandom));
      @(negedge clk);
      n_checks++;
      if ({Fault, Stall, mif.MemReq, RegWrite} !== 4'b1100) begin
        n_fails++; $display("FAIL fault_sticky flt/stall/req/rw got %b exp 1100",
                            {Fault, Stall, mif.MemReq, RegWrite});
      end
    end
    do_reset();
    n_checks++;
    if (Fault !== 1'b0) begin
      n_fails++; $display("FAIL fault_cleared Fault got %b exp 0", Fault);
    end
  endtask

  task automatic test_illegal();
    drive(1'b1, 1'b1, 1'b1, 32'h10, 1'b1, 32'd1);
    @(negedge clk);
    n_checks++;
    if (mif.MemReq !== 1'b0) begin
      n_fails++; $display("FAIL illegal_noreq MemReq got %b exp 0", mif.MemReq);
    end
    drive(1'b0, 1'b0, 1'b0, 32'h10, 1'b0, 32'd0);
    @(negedge clk);
    n_checks++;
    if (Fault !== 1'b1) begin
      n_fails++; $display("FAIL illegal_fault Fault got %b exp 1", Fault);
    end
    do_reset();
  endtask

  task automatic test_reset_mid_access();
    drive(1'b1, 1'b0, 1'b1, 32'h60, 1'b0, 32'd0);
    drive(1'b1, 1'b0, 1'b1, 32'h60, 1'b0, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({mif.MemReq, Stall} !== 2'b00) begin
      n_fails++; $display("FAIL rst_mid_req req/stall got %b exp 00", {mif.MemReq, Stall});
    end
    drive(1'b0, 1'b0, 1'b1, 32'd77, 1'b0, 32'd0);
    reset = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({Stall, mif.MemReq, RegWrite} !== 3'b001 || Result !== 32'd77) begin
      n_fails++; $display("FAIL rst_mid_idle stall/req/rw got %b result %0d exp 001 result 77",
                          {Stall, mif.MemReq, RegWrite}, Result);
    end
  endtask

  task automatic test_zero_wait();
    int n_stall;
    n_stall = 0;
    drive(1'b1, 1'b0, 1'b1, 32'h80, 1'b1, 32'd200);
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (!Stall) break;
      n_stall++;
      drive(1'b1, 1'b0, 1'b1, 32'h80, 1'b1, 32'd200);
    end
    n_checks++;
    if (n_stall !== (ZW ? 1 : 2)) begin
      n_fails++; $display("FAIL zw_stall_cycles got %0d exp %0d", n_stall, ZW ? 1 : 2);
    end
    n_checks++;
    if (ResultSrc !== 1'b1 || Result !== 32'd200) begin
      n_fails++; $display("FAIL zw_result src %b result %0d exp src 1 result 200", ResultSrc, Result);
    end
    drive(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    for (int t = 0; t < 40; t++) begin
      int op, k;
      op = $urandom_range(0, 2);
      k  = ($urandom_range(0, 7) == 0) ? TO : $urandom_range(0, 5);
      run_txn($sformatf("rand%0d", t), op, k, W'($urandom), W'($urandom),
              (op == 2) ? 1'b0 : 1'($urandom_range(0, 1)));
    end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_load();
    test_store();
    test_ready_at_limit();
    test_timeout();
    test_illegal();
    test_reset_mid_access();
    test_zero_wait();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
